// File: rtl/regfile_master_pkg.sv
// Shared types and defaults for the register-file sequential Avalon-MM master.
// Holds the FSM state encoding and the legal read-latency range.
package regfile_master_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_rdlat_pipe.sv
// Valid shift pipe that tracks read data returning a fixed number of cycles after
// each completed read; empty reports whether the pipe holds nothing after this edge.
module regfile_rdlat_pipe #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    output logic vld_out,
    output logic empty
);

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] vld_nxt;

    always_comb begin
        vld_nxt    = '0;
        vld_nxt[0] = push;
        for (int i = 1; i < STAGES; i++) begin
            vld_nxt[i] = vld_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= vld_nxt;
        end
    end

    assign vld_out = vld_p[STAGES-1];
    // Looks one edge ahead so the FSM can leave READ exactly as the last word emerges.
    assign empty   = ~|vld_nxt;

endmodule

// File: rtl/regfile_seq_master.sv
// Avalon-MM master running N sequential word writes (from a valid/ready stream)
// or reads (to a valid-only stream) against the 32x32 on-chip register file.
module regfile_seq_master
    import regfile_master_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BE_W         = DATA_W / 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rnw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic [BE_W-1:0]   cmd_be,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic [BE_W-1:0]   avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int RD_LAT = (READ_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                            (READ_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : READ_LATENCY;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [BE_W-1:0]   BE_ALL   = {BE_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   issue_left;
    logic [ADDR_W:0]   comp_left;
    logic [BE_W-1:0]   be_q;

    logic cmd_take;
    logic xfer_done;
    logic slot_free;
    logic wr_take;
    logic rd_issue;
    logic issue;
    logic rd_push;
    logic pipe_empty;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign cmd_take  = cmd_valid & cmd_ready;

    // A new transfer may be launched when the bus slot is empty or frees on this edge.
    assign xfer_done = avm_chipselect & ~avm_waitrequest;
    assign slot_free = ~avm_chipselect | ~avm_waitrequest;

    assign wr_ready  = (state == WRITE) & (issue_left != '0) & slot_free;
    assign wr_take   = wr_valid & wr_ready;
    assign rd_issue  = (state == READ) & (issue_left != '0) & slot_free;
    assign issue     = wr_take | rd_issue;
    assign rd_push   = xfer_done & (state == READ);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count == '0) begin
                        state_nxt = FINISH;
                    end else if (cmd_rnw) begin
                        state_nxt = READ;
                    end else begin
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                if (xfer_done && (comp_left == CNT_ONE)) begin
                    state_nxt = FINISH;
                end
            end
            READ: begin
                if ((comp_left == '0) && pipe_empty) begin
                    state_nxt = FINISH;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            issue_left <= '0;
            comp_left  <= '0;
            be_q       <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_take) begin
                addr_q     <= cmd_addr;
                issue_left <= cmd_count;
                comp_left  <= cmd_count;
                be_q       <= cmd_be;
            end else begin
                if (issue) begin
                    addr_q     <= addr_q + ADDR_ONE;
                    issue_left <= issue_left - CNT_ONE;
                end
                if (xfer_done) begin
                    comp_left <= comp_left - CNT_ONE;
                end
            end
        end
    end

    // Bus stage: only changes when a transfer is launched or retires, so a stall holds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else if (issue) begin
            avm_chipselect <= 1'b1;
            avm_write      <= wr_take;
            avm_address    <= addr_q;
            avm_byteenable <= wr_take ? be_q : BE_ALL;
            if (wr_take) begin
                avm_writedata <= wr_data;
            end
        end else if (xfer_done) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
        end
    end

    regfile_rdlat_pipe #(
        .STAGES (RD_LAT)
    ) u_rdlat_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rd_push),
        .vld_out (rd_valid),
        .empty   (pipe_empty)
    );

    assign rd_data = rd_valid ? avm_readdata : '0;

endmodule

// File: tb/tb_regfile_seq_master.sv
// Bench for regfile_seq_master: behavioural register-file slave on the bus and a
// word-array reference model of the expected memory contents and transfer order.
module tb_regfile_seq_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RL = 1;
    localparam int NW = 32;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rnw;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_count;
    logic [BW-1:0] cmd_be;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_byteenable;
    logic          avm_chipselect;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    regfile_seq_master #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .BE_W         (BW),
        .READ_LATENCY (RL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_rnw         (cmd_rnw),
        .cmd_addr        (cmd_addr),
        .cmd_count       (cmd_count),
        .cmd_be          (cmd_be),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32x32 register-file slave with one-cycle read latency.
    logic [DW-1:0] smem [NW];
    logic [DW-1:0] init_val [NW];
    logic          mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NW; i++) smem[i] <= init_val[i];
        end else if (avm_chipselect && !avm_waitrequest) begin
            if (avm_write) begin
                for (int b = 0; b < BW; b++)
                    if (avm_byteenable[b]) smem[avm_address][8*b +: 8] <= avm_writedata[8*b +: 8];
            end else begin
                avm_readdata <= smem[avm_address];
            end
        end
    end

    logic [DW-1:0] exp_mem [NW];

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        int            cyc;
    } xfer_t;

    xfer_t         xq[$];
    logic [DW-1:0] rdq[$];
    int            rd_cyc[$];
    int            done_cyc;
    int            cmd_cyc;
    bit            timed_out;
    int            hold_viol;
    int            stall_seen;
    int            cs_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] waddr(input int a, input int i);
        return AW'((a + i) % NW);
    endfunction

    // Issues one command, feeds write words, records bus completions, read words and done.
    task automatic run_cmd(input bit rnw, input int a, input int n, input logic [BW-1:0] be,
                           input int stall_mode, input logic [DW-1:0] words[$]);
        int            idx;
        bit            w;
        bit            prev_stall;
        logic [AW-1:0] p_addr;
        logic          p_wr;
        logic [DW-1:0] p_data;
        logic [BW-1:0] p_be;
        xq.delete(); rdq.delete(); rd_cyc.delete();
        hold_viol = 0; stall_seen = 0; cs_cycles = 0; done_cyc = -1; timed_out = 1'b1;
        idx = 0; prev_stall = 1'b0;
        p_addr = '0; p_wr = 1'b0; p_data = '0; p_be = '0;
        @(negedge clk);
        avm_waitrequest = 1'b0;
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = AW'(a); cmd_count = (AW+1)'(n); cmd_be = be;
        #1 cmd_cyc = cyc;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            case (stall_mode)
                1:       w = ($urandom_range(0, 2) == 0);
                2:       w = (k == 3 || k == 4);
                default: w = 1'b0;
            endcase
            avm_waitrequest = w;
            wr_valid = !rnw && (idx < n);
            wr_data  = (idx < n) ? words[idx] : '0;
            #1;
            if (prev_stall && (!avm_chipselect || avm_address != p_addr || avm_write != p_wr ||
                               avm_writedata != p_data || avm_byteenable != p_be))
                hold_viol++;
            if (avm_chipselect) cs_cycles++;
            if (avm_chipselect && w) stall_seen++;
            prev_stall = avm_chipselect && w;
            p_addr = avm_address; p_wr = avm_write; p_data = avm_writedata; p_be = avm_byteenable;
            if (avm_chipselect && !w)
                xq.push_back('{avm_address, avm_write, avm_writedata, avm_byteenable, cyc});
            if (rd_valid) begin
                rdq.push_back(rd_data);
                rd_cyc.push_back(cyc);
            end
            if (wr_valid && wr_ready) idx++;
            if (done) begin
                done_cyc = cyc; timed_out = 1'b0;
                break;
            end
        end
        wr_valid = 1'b0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({cmd_ready, busy, done, avm_chipselect, avm_write, wr_ready, rd_valid} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 1000000",
                     {cmd_ready, busy, done, avm_chipselect, avm_write, wr_ready, rd_valid});
        end
        n_checks++;
        if ({avm_address, avm_byteenable, avm_writedata, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h be=%h wd=%h rd=%h required all zero",
                     avm_address, avm_byteenable, avm_writedata, rd_data);
        end
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] words[$];
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        run_cmd(1'b0, 3, 4, 4'hF, 0, words);
        n_checks++;
        if (timed_out || xq.size() != 4) begin
            n_fail++;
            $display("FAIL wr4_count: got %0d writes timeout=%0d required 4", xq.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if ({xq[i].addr, xq[i].wr, xq[i].data, xq[i].be} !== {waddr(3, i), 1'b1, words[i], 4'hF}) begin
                    n_fail++;
                    $display("FAIL wr4_xfer%0d: got a=%0d w=%0d d=%h be=%h required a=%0d w=1 d=%h be=f",
                             i, xq[i].addr, xq[i].wr, xq[i].data, xq[i].be, waddr(3, i), words[i]);
                end
                n_checks++;
                if (xq[i].cyc !== xq[0].cyc + i) begin
                    n_fail++;
                    $display("FAIL wr4_rate%0d: got cycle %0d required %0d", i, xq[i].cyc, xq[0].cyc + i);
                end
                exp_mem[waddr(3, i)] = words[i];
            end
            n_checks++;
            if (done_cyc !== xq[3].cyc + 1) begin
                n_fail++;
                $display("FAIL wr4_done: got cycle %0d required %0d", done_cyc, xq[3].cyc + 1);
            end
        end
    endtask

    task automatic test_read_burst();
        logic [DW-1:0] none[$];
        run_cmd(1'b1, 3, 4, 4'h0, 0, none);
        n_checks++;
        if (timed_out || xq.size() != 4 || rdq.size() != 4) begin
            n_fail++;
            $display("FAIL rd4_count: got %0d reads %0d words timeout=%0d required 4/4",
                     xq.size(), rdq.size(), timed_out);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if ({xq[i].addr, xq[i].wr, xq[i].be} !== {waddr(3, i), 1'b0, 4'hF}) begin
                    n_fail++;
                    $display("FAIL rd4_xfer%0d: got a=%0d w=%0d be=%h required a=%0d w=0 be=f",
                             i, xq[i].addr, xq[i].wr, xq[i].be, waddr(3, i));
                end
                n_checks++;
                if (rdq[i] !== exp_mem[waddr(3, i)]) begin
                    n_fail++;
                    $display("FAIL rd4_data%0d: got %h required %h", i, rdq[i], exp_mem[waddr(3, i)]);
                end
                n_checks++;
                if (rd_cyc[i] !== xq[i].cyc + RL) begin
                    n_fail++;
                    $display("FAIL rd4_lat%0d: got cycle %0d required %0d", i, rd_cyc[i], xq[i].cyc + RL);
                end
            end
            n_checks++;
            if (done_cyc !== rd_cyc[3] + 1) begin
                n_fail++;
                $display("FAIL rd4_done: got cycle %0d required %0d", done_cyc, rd_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] words[$];
        logic [DW-1:0] none[$];
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0;
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_cmd(1'b0, 30, 3, 4'hF, 0, words);
        n_checks++;
        if (timed_out || xq.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_wr_count: got %0d required 3", xq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (xq[i].addr !== exp_a[i]) begin
                    n_fail++;
                    $display("FAIL wrap_addr%0d: got %0d required %0d", i, xq[i].addr, exp_a[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) exp_mem[waddr(30, i)] = words[i];
        run_cmd(1'b1, 30, 3, 4'h0, 0, none);
        n_checks++;
        if (timed_out || rdq.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_rd_count: got %0d required 3", rdq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rdq[i] !== words[i]) begin
                    n_fail++;
                    $display("FAIL wrap_data%0d: got %h required %h", i, rdq[i], words[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] words[$];
        logic [DW-1:0] none[$];
        for (int i = 0; i < 6; i++) words.push_back($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            run_cmd(pass == 1, 8, 6, 4'hF, 2, (pass == 1) ? none : words);
            n_checks++;
            if (stall_seen != 2 || hold_viol != 0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got stalls=%0d violations=%0d required 2/0",
                         pass, stall_seen, hold_viol);
            end
            n_checks++;
            if (timed_out || xq.size() != 6) begin
                n_fail++;
                $display("FAIL stall_count%0d: got %0d transfers required 6", pass, xq.size());
            end else begin
                for (int i = 0; i < 6; i++) begin
                    n_checks++;
                    if ({xq[i].addr, xq[i].wr} !== {waddr(8, i), pass == 0} ||
                        (pass == 0 && xq[i].data !== words[i])) begin
                        n_fail++;
                        $display("FAIL stall_xfer%0d_%0d: got a=%0d w=%0d d=%h required a=%0d",
                                 pass, i, xq[i].addr, xq[i].wr, xq[i].data, waddr(8, i));
                    end
                    if (pass == 0) exp_mem[waddr(8, i)] = words[i];
                end
            end
            if (pass == 1) begin
                n_checks++;
                if (rdq.size() != 6) begin
                    n_fail++;
                    $display("FAIL stall_rdcount: got %0d required 6", rdq.size());
                end else begin
                    for (int i = 0; i < 6; i++) begin
                        n_checks++;
                        if (rdq[i] !== words[i]) begin
                            n_fail++;
                            $display("FAIL stall_data%0d: got %h required %h", i, rdq[i], words[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_byteenable();
        logic [DW-1:0] w1[$];
        logic [DW-1:0] w2[$];
        logic [DW-1:0] none[$];
        w1.push_back(32'hFFFFFFFF);
        w2.push_back(32'hAABBCCDD);
        run_cmd(1'b0, 12, 1, 4'hF, 0, w1);
        run_cmd(1'b0, 12, 1, 4'b0011, 0, w2);
        exp_mem[12] = merge_be(merge_be(exp_mem[12], 32'hFFFFFFFF, 4'hF), 32'hAABBCCDD, 4'b0011);
        run_cmd(1'b1, 12, 1, 4'h0, 0, none);
        n_checks++;
        if (rdq.size() != 1 || rdq[0] !== 32'hFFFFCCDD) begin
            n_fail++;
            $display("FAIL be_merge: got %0d words first=%h required 1 word ffffccdd", rdq.size(), rdq[0]);
        end
    endtask

    task automatic test_zero_count();
        logic [DW-1:0] none[$];
        run_cmd(1'b0, 7, 0, 4'hF, 0, none);
        n_checks++;
        if (timed_out || done_cyc !== cmd_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_done: got cycle %0d required %0d", done_cyc, cmd_cyc + 1);
        end
        n_checks++;
        if (cs_cycles != 0) begin
            n_fail++;
            $display("FAIL zero_bus: got %0d chipselect cycles required 0", cs_cycles);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] words[$];
        bit            rnw;
        int            a;
        int            n;
        logic [BW-1:0] be;
        logic [BW-1:0] ebe;
        for (int t = 0; t < 10; t++) begin
            rnw = 1'($urandom_range(0, 1));
            a   = $urandom_range(0, NW - 1);
            n   = $urandom_range(0, 12);
            be  = BW'($urandom_range(1, 15));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_cmd(rnw, a, n, be, 1, words);
            n_checks++;
            if (timed_out || xq.size() != n || (rnw && rdq.size() != n) || hold_viol != 0) begin
                n_fail++;
                $display("FAIL rand%0d_count: got xfers=%0d words=%0d holdviol=%0d timeout=%0d required %0d",
                         t, xq.size(), rdq.size(), hold_viol, timed_out, n);
            end else begin
                ebe = rnw ? 4'hF : be;
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if ({xq[i].addr, xq[i].wr, xq[i].be} !== {waddr(a, i), !rnw, ebe} ||
                        (!rnw && xq[i].data !== words[i]) ||
                        (rnw && rdq[i] !== exp_mem[waddr(a, i)])) begin
                        n_fail++;
                        $display("FAIL rand%0d_xfer%0d: got a=%0d w=%0d be=%h wd=%h rd=%h required a=%0d",
                                 t, i, xq[i].addr, xq[i].wr, xq[i].be, xq[i].data,
                                 rnw ? rdq[i] : 32'h0, waddr(a, i));
                    end
                    if (!rnw) exp_mem[waddr(a, i)] = merge_be(exp_mem[waddr(a, i)], words[i], be);
                end
            end
        end
    endtask

    task automatic test_reset_midread();
        int done_seen;
        int cs_seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 5'd0; cmd_count = 6'd16; cmd_be = 4'h0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_busy: got %b required 1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, busy, done, avm_chipselect, avm_write, wr_ready, rd_valid} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL midread_rst_ctrl: got %b required 1000000",
                     {cmd_ready, busy, done, avm_chipselect, avm_write, wr_ready, rd_valid});
        end
        n_checks++;
        if ({avm_address, avm_byteenable, avm_writedata, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL midread_rst_data: addr=%h be=%h wd=%h rd=%h required all zero",
                     avm_address, avm_byteenable, avm_writedata, rd_data);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0; cs_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (done || rd_valid) done_seen++;
            if (avm_chipselect) cs_seen++;
        end
        n_checks++;
        if (done_seen != 0 || cs_seen != 0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_abort: got done/rd=%0d cs=%0d ready=%b required 0/0/1",
                     done_seen, cs_seen, cmd_ready);
        end
    endtask

    initial begin
        reset_n = 1'b0; mem_init = 1'b1;
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_count = '0; cmd_be = '0;
        wr_valid = 1'b0; wr_data = '0; avm_waitrequest = 1'b0;
        for (int i = 0; i < NW; i++) begin
            init_val[i] = $urandom;
            exp_mem[i]  = init_val[i];
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        test_reset();
        mem_init = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_stall();
        test_byteenable();
        test_zero_count();
        test_random();
        test_reset_midread();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
